// File: rtl/sys_call_unit.sv
// sys_call_unit: turns a decoded SYSCALL into the sysc_mp / sys_op / sys_inf_out
// handshake, stalls the PC while the responder settles, writes the returned
// value back to $v0 for input syscalls, and halts stickily on exit.
module sys_call_unit #(
    parameter int OP_W       = 4,
    parameter int SETTLE     = 2,   // 1..15
    parameter int OP_OUT_INT = 1,
    parameter int OP_IN_INT  = 5,
    parameter int OP_EXIT    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sysc_req,
    input  logic [OP_W-1:0] op_in,
    input  logic [31:0]     arg_in,
    input  logic [31:0]     sys_inf_in,
    output logic            stall,
    output logic            sysc_mp,
    output logic [OP_W-1:0] sys_op,
    output logic [31:0]     sys_inf_out,
    output logic            wb_en,
    output logic [31:0]     wb_data,
    output logic            halt,
    output logic [7:0]      sys_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_WB,
        S_HALT
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       req_io;
    logic       req_exit;

    // Decode of the requested syscall; any other code is a silent NOP.
    assign req_io   = sysc_req && ((op_in == OP_W'(OP_OUT_INT)) || (op_in == OP_W'(OP_IN_INT)));
    assign req_exit = sysc_req && (op_in == OP_W'(OP_EXIT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Latched request, settle counter and completed-call counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_op      <= '0;
            sys_inf_out <= '0;
            wait_cnt    <= '0;
            sys_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // sys_op/sys_inf_out are only overwritten by an accepted call
                    if (req_io || req_exit) sys_op <= op_in;
                    if (req_io) begin
                        sys_inf_out <= arg_in;
                        wait_cnt    <= 4'(SETTLE);
                    end
                end
                S_WAIT:  wait_cnt <= wait_cnt - 4'd1;
                S_WB:    sys_cnt  <= sys_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    // Next state and combinational handshake outputs.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        sysc_mp   = 1'b0;
        wb_en     = 1'b0;
        wb_data   = '0;
        halt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_exit) begin
                    stall     = 1'b1;
                    state_nxt = S_HALT;
                end else if (req_io) begin
                    stall     = 1'b1;
                    state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                stall     = 1'b1;
                sysc_mp   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (wait_cnt <= 4'd1) state_nxt = S_WB;
            end
            S_WB: begin
                // stall low here lets the PC step past the SYSCALL
                if (sys_op == OP_W'(OP_IN_INT)) begin
                    wb_en   = 1'b1;
                    wb_data = sys_inf_in;
                end
                state_nxt = S_IDLE;
            end
            S_HALT: begin
                stall = 1'b1;
                halt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        // keep every output quiet while reset is held, even with a pending request
        if (rst) begin
            stall   = 1'b0;
            sysc_mp = 1'b0;
            wb_en   = 1'b0;
            wb_data = '0;
            halt    = 1'b0;
        end
    end

endmodule

// File: doc/sys_call_unit.md
# sys_call_unit

CPU-side initiator of the syscall interface between the single-cycle CPU and the board I/O layer. It sits inside the CPU control path and turns a decoded SYSCALL instruction into the `sysc_mp` / `sys_op` / `sys_inf_out` handshake that the array-buffer responder consumes. It stalls the PC while the responder settles, then writes the returned `sys_inf_in` value back to the register file. It also raises a sticky halt on the exit syscall.

## Interface
- `OP_W`, 4: width of `sys_op` (matches `SYS_OP_LENGTH`).
- `SETTLE`, 2: cycles waited after the pulse before sampling `sys_inf_in`; legal range 1..15.
- `OP_OUT_INT`, 1: syscall code for output integer (`$a0` to the responder).
- `OP_IN_INT`, 5: syscall code for input integer (responder to `$v0`).
- `OP_EXIT`, 10: syscall code for halt.

Ports:
- `clk` input 1: CPU clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sysc_req` input 1: the current instruction is SYSCALL.
- `op_in` input OP_W: low bits of `$v0`.
- `arg_in` input 32: `$a0`.
- `sys_inf_in` input 32: data from the responder.
- `stall` output 1: hold the PC and suppress normal writeback.
- `sysc_mp` output 1: one-cycle pulse to the responder.
- `sys_op` output OP_W: registered syscall code.
- `sys_inf_out` output 32: registered argument.
- `wb_en` output 1: write `wb_data` to `$v0` this cycle.
- `wb_data` output 32: writeback value.
- `halt` output 1: sticky halt.
- `sys_cnt` output 8: completed-syscall counter (debug).

## Operation
- States: IDLE, PULSE, WAIT, WB, HALT. Reset state: IDLE.
- IDLE:
  - `sysc_req`=1 and `op_in`∈{OP_OUT_INT, OP_IN_INT}: latch `op_in` into `sys_op` and `arg_in` into `sys_inf_out`, load the wait counter with SETTLE, go to PULSE.
  - `sysc_req`=1 and `op_in`=OP_EXIT: latch `sys_op`, set `halt`, go to HALT. No pulse is issued.
  - `sysc_req`=1 with any other code: treated as NOP. No stall, no pulse, state stays IDLE.
- PULSE: `sysc_mp`=1 for exactly this cycle, then go to WAIT.
- WAIT: decrement the counter each cycle; when it reaches 1, go to WB.
- WB:
  - OP_IN_INT: `wb_en`=1 and `wb_data`=`sys_inf_in` as sampled in this cycle, unmodified 32 bits.
  - OP_OUT_INT: `wb_en`=0.
  - Increment `sys_cnt` (mod 256, wraps 255→0). Go to IDLE. `sysc_req` is ignored in WB.
- HALT: absorbing until `rst`. `stall`=1 and `halt`=1. `sysc_req` is ignored.
- `stall` is combinational:
  - 1 in IDLE when `sysc_req` is 1 with a known code.
  - 1 in PULSE, WAIT and HALT.
  - 0 in WB, so the PC advances past the SYSCALL at the end of WB.
- `sys_op` and `sys_inf_out` hold from PULSE until the next accepted syscall; they are not cleared in IDLE.
- `wb_data` is 0 whenever `wb_en`=0.

## Timing
- Reset values (asynchronous): state IDLE; `sysc_mp`, `wb_en`, `halt`, `stall`=0; `sys_op`, `sys_inf_out`, `wb_data`, `sys_cnt`=0.
- Cycle numbering for one accepted syscall, where cycle 0 is the IDLE cycle with `sysc_req`:
  - `sys_op` and `sys_inf_out` are valid from cycle 1.
  - `sysc_mp` is high in cycle 1 only.
  - WAIT occupies cycles 2..SETTLE+1.
  - WB is cycle SETTLE+2.
  - `stall` is high in cycles 0..SETTLE+1.
  - Total occupancy is SETTLE+3 cycles.
- The responder captures on the `sysc_mp` rising edge. `sys_inf_in` must be stable by WB; it is not sampled earlier.
- Reset asserted mid-operation: immediate return to IDLE. The pulse is truncated and no writeback occurs.
- `sysc_mp` never reasserts without an intervening return to IDLE. The minimum spacing between pulses is SETTLE+3 cycles.

## Test plan
- Reset values: assert `rst` mid-WAIT → all outputs 0 in the same cycle; after release, state is IDLE.
- OP_IN_INT with SETTLE=2, `sys_inf_in`=0x0000_0007 → `sysc_mp` high in cycle 1 only; `stall` high in cycles 0–3; cycle 4 shows `wb_en`=1 and `wb_data`=7; `sys_cnt`=1.
- OP_OUT_INT with `arg_in`=0x0000_002A → `sys_inf_out`=0x2A and `sys_op`=1 from cycle 1; `wb_en` stays 0 throughout; `stall` drops in cycle 4.
- OP_EXIT → `halt`=1 from cycle 1 and `stall` stays 1 indefinitely; `sysc_mp` is never pulsed; further `sysc_req` has no effect until `rst`.
- Unknown code 3 → `stall`, `sysc_mp` and `wb_en` stay 0; `sys_cnt` unchanged.
- 256 back-to-back OP_OUT_INT calls → `sys_cnt` wraps to 0; consecutive `sysc_mp` pulses are exactly SETTLE+3 cycles apart.
